byte_frame_packer: RTL and testbench
====================================

// Module: byte_frame_packer
//
// PURPOSE
//   Downstream consumer of the 8-bit byte stream read out of the 16-entry register array stage.
//   Packs consecutive payload bytes into fixed-length frames: SYNC header, FRAME_LEN payload
//   bytes, two's-complement checksum trailer. Valid/ready on both sides; one registered output
//   slice, so downstream backpressure propagates to in_ready without losing or duplicating bytes.
//
// PARAMETERS
//   FRAME_LEN  16     payload bytes per frame; legal range 1..256 (matches array depth by default)
//   SYNC_BYTE  8'hA5  header byte emitted at start of every frame
//
// PORTS
//   clk        in   1  clock, all state on rising edge
//   rst        in   1  reset, asynchronous, active-high
//   in_data    in   8  payload byte from array stage
//   in_valid   in   1  in_data valid
//   in_ready   out  1  packer accepts in_data this cycle (in_valid && in_ready = accept)
//   out_data   out  8  framed byte (header, payload or checksum)
//   out_valid  out  1  out_data valid
//   out_ready  in   1  downstream accepts out_data (out_valid && out_ready = accept)
//   out_sof    out  1  qualifies out_data as SYNC header byte
//   out_eof    out  1  qualifies out_data as checksum byte
//   frame_cnt  out  8  completed frames, mod 256
//
// BEHAVIOUR
//   - Reset: out_valid=0, out_data=0, out_sof=0, out_eof=0, frame_cnt=0, in_ready=0,
//     state=IDLE, byte index=0, checksum accumulator=0. Reset mid-frame discards the partial
//     frame; the next frame starts with SYNC and a fresh checksum.
//   - Output slice: registered; may load when !out_valid || out_ready ("slot free").
//     While out_valid && !out_ready: out_data/out_sof/out_eof held stable.
//   - FSM states: IDLE, HDR, PAYLOAD, CSUM.
//     IDLE: in_ready=0; on in_valid -> HDR (byte not consumed).
//     HDR: when slot free, load SYNC_BYTE, out_sof=1; clear accumulator and index -> PAYLOAD.
//     PAYLOAD: in_ready = slot free. On accept: load in_data, sum += in_data (mod 256),
//       index++. Accept of byte FRAME_LEN-1 -> CSUM.
//     CSUM: in_ready=0; when slot free, load (~sum + 1) mod 256, out_eof=1 -> HDR if in_valid
//       else IDLE. frame_cnt increments when the checksum byte is accepted downstream.
//   - Latency: input accept to out_valid = 1 cycle. Back-to-back frames have no idle cycles:
//     sustained throughput is FRAME_LEN+2 output bytes per FRAME_LEN+2 cycles.
//   - Invariant: (sum of payload bytes + checksum byte) mod 256 == 0.
//   - out_valid deasserts when slot drains and nothing new loads (in_valid gap in PAYLOAD).
//   - Index width = max(1, $clog2(FRAME_LEN)); FRAME_LEN=1 goes HDR->PAYLOAD->CSUM.
//   - frame_cnt wraps 255 -> 0 silently.
//   - Frame-completion increment and simultaneous new-frame SYNC load in the same cycle are
//     both honoured.
//
// STRUCTURE
//   - Shared package frame_pkg: state enum (IDLE/HDR/PAYLOAD/CSUM), SYNC_BYTE default
//     constant, function csum8(sum) = ~sum + 1.
//   - One sub-module: byte_out_slice (data+sof+eof register with valid/ready, slot_free
//     output). FSM, index counter, accumulator and frame_cnt live in byte_frame_packer.
//
// TESTING
//   1. FRAME_LEN=4, in 01 02 03 04, out_ready=1 -> out A5(sof) 01 02 03 04 F6(eof);
//      frame_cnt=1.
//   2. out_ready=0 for 3 cycles after payload byte 02 -> out_data holds 02, in_ready=0,
//      stream resumes with 03, no loss/dup.
//   3. Continuous in_valid, 3 frames -> A5 directly follows each eof byte; frame_cnt=3;
//      no bubbles.
//   4. in_valid gaps of 2 cycles inside payload -> out_valid low during gap; checksum still
//      correct.
//   5. rst pulsed after 2 payload bytes -> all outputs at reset values; next frame starts
//      A5, csum of new bytes only.
//   6. FRAME_LEN=4 payload FF FF FF FF -> csum 04; run 256 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared definitions for the byte frame packer: FSM state encoding, default sync byte and
// the two's-complement checksum helper.
package frame_pkg;

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StHdr     = 2'd1;
   localparam logic [1:0] StPayload = 2'd2;
   localparam logic [1:0] StCsum    = 2'd3;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   // Checksum byte that makes (payload sum + checksum) mod 256 == 0.
   function automatic logic [7:0] csum8(input logic [7:0] sum);
      return ~sum + 8'd1;
   endfunction

endpackage

// File: rtl/byte_out_slice.sv
// Single registered output stage carrying a byte plus sof/eof markers under valid/ready.
// slot_free tells the producer it may load a new entry this cycle.
module byte_out_slice (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_data,
   input  logic       load_sof,
   input  logic       load_eof,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_sof,
   output logic       out_eof,
   output logic       slot_free
);

   assign slot_free = !out_valid || out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= 8'd0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
      end else if (slot_free) begin
         out_valid <= load;
         if (load) begin
            out_data <= load_data;
            out_sof  <= load_sof;
            out_eof  <= load_eof;
         end
      end
   end

endmodule

// File: rtl/byte_frame_packer.sv
// Packs payload bytes into frames of SYNC header, FRAME_LEN payload bytes and a checksum
// trailer, with a single registered output stage and valid/ready on both sides.
module byte_frame_packer
   import frame_pkg::*;
#(
   parameter int unsigned FRAME_LEN = 16,
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_sof,
   output logic       out_eof,
   output logic [7:0] frame_cnt
);

   localparam int unsigned IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       sum_q, sum_d;
   logic [7:0]       frame_cnt_q;

   logic       slot_free;
   logic       load;
   logic [7:0] load_data;
   logic       load_sof;
   logic       load_eof;

   assign in_ready  = (state_q == StPayload) && slot_free;
   assign frame_cnt = frame_cnt_q;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      sum_d     = sum_q;
      load      = 1'b0;
      load_data = 8'd0;
      load_sof  = 1'b0;
      load_eof  = 1'b0;
      case (state_q)
         StIdle: begin
            if (in_valid) state_d = StHdr;
         end
         StHdr: begin
            if (slot_free) begin
               load      = 1'b1;
               load_data = SYNC_BYTE;
               load_sof  = 1'b1;
               sum_d     = 8'd0;
               idx_d     = '0;
               state_d   = StPayload;
            end
         end
         StPayload: begin
            if (in_valid && in_ready) begin
               load      = 1'b1;
               load_data = in_data;
               sum_d     = sum_q + in_data;
               idx_d     = idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) state_d = StCsum;
            end
         end
         default: begin
            if (slot_free) begin
               load      = 1'b1;
               load_data = csum8(sum_q);
               load_eof  = 1'b1;
               state_d   = in_valid ? StHdr : StIdle;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         sum_q       <= 8'd0;
         frame_cnt_q <= 8'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         // Counts on downstream acceptance of the trailer, independent of any SYNC load.
         if (out_valid && out_ready && out_eof) frame_cnt_q <= frame_cnt_q + 8'd1;
      end
   end

   byte_out_slice u_slice (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_data (load_data),
      .load_sof  (load_sof),
      .load_eof  (load_eof),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_sof   (out_sof),
      .out_eof   (out_eof),
      .slot_free (slot_free)
   );

endmodule

// File: tb/tb_byte_frame_packer.sv
// Self-checking bench for byte_frame_packer with FRAME_LEN=4: table-driven frames plus
// backpressure, back-to-back, gap, reset and frame counter wrap sequences.
module tb_byte_frame_packer;

   localparam int unsigned FL = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'd0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       out_sof;
   logic       out_eof;
   logic [7:0] frame_cnt;

   int errors = 0;
   int checks = 0;

   byte_frame_packer #(.FRAME_LEN(FL), .SYNC_BYTE(8'hA5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sof   (out_sof),
      .out_eof   (out_eof),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0][7:0] p;
      logic [7:0]      csum;
   } vec_t;

   logic [9:0] sb_q[$];          // {sof, eof, data}
   int         m_idx = 0;
   int         m_sum = 0;
   int         cyc = 0;
   int         sof_cyc = -1;
   int         eof_cyc = -1;
   logic [7:0] last_csum = 8'd0;
   int         frames_sent = 0;
   bit         saw_255 = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model and scoreboard: everything judged at the negedge before the handshake edge.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         sb_q.delete();
         m_idx = 0;
         m_sum = 0;
      end else begin
         if (frame_cnt == 8'd255) saw_255 = 1'b1;
         if (in_valid && in_ready) begin
            if (m_idx == 0) begin
               sb_q.push_back({1'b1, 1'b0, 8'hA5});
               m_sum = 0;
            end
            sb_q.push_back({2'b00, in_data});
            m_sum = m_sum + int'(in_data);
            m_idx++;
            if (m_idx == FL) begin
               sb_q.push_back({2'b01, 8'((256 - (m_sum % 256)) % 256)});
               m_idx = 0;
            end
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_output", int'({out_sof, out_eof, out_data}), 0);
            end else begin
               chk("stream_byte", int'({out_sof, out_eof, out_data}), int'(sb_q.pop_front()));
            end
            if (out_sof && sof_cyc < 0) sof_cyc = cyc;
            if (out_eof) begin
               last_csum = out_data;
               eof_cyc   = cyc;
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (n >= 200) chk("in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         if (g == gap - 1 && gap >= 2) chk("gap_out_valid_low", int'(out_valid), 0);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [3:0][7:0] p, input int gap);
      for (int i = 0; i < FL; i++) send_byte(p[i], (i == FL - 1) ? 0 : gap);
      frames_sent++;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((sb_q.size() != 0 || out_valid) && n < 200);
      if (n >= 200) chk("drain_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_sof_eof", int'({out_sof, out_eof}), 0);
      chk("rst_frame_cnt", int'(frame_cnt), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      frames_sent = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   vec_t vecs[6];
   logic [3:0][7:0] ff_frame;

   initial begin
      vecs[0] = '{p: {8'h04, 8'h03, 8'h02, 8'h01}, csum: 8'hF6};
      vecs[1] = '{p: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, csum: 8'h04};
      vecs[2] = '{p: {8'h00, 8'h00, 8'h00, 8'h00}, csum: 8'h00};
      vecs[3] = '{p: {8'h40, 8'h30, 8'h20, 8'h10}, csum: 8'h60};
      vecs[4] = '{p: {8'h01, 8'h00, 8'h01, 8'h7F}, csum: 8'h7F};
      vecs[5] = '{p: {8'h44, 8'h33, 8'h22, 8'h11}, csum: 8'h56};
      ff_frame = {8'hFF, 8'hFF, 8'hFF, 8'hFF};

      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Table-driven single frames with full downstream readiness.
      for (int v = 0; v < 5; v++) begin
         send_frame(vecs[v].p, 0);
         wait_drain();
         chk("table_csum", int'(last_csum), int'(vecs[v].csum));
         chk("table_frame_cnt", int'(frame_cnt), frames_sent % 256);
      end

      // Backpressure: stall while payload byte 02 sits in the output slot.
      fork
         send_frame(vecs[0].p, 0);
         begin
            int n;
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!(out_valid && out_data == 8'h01 && !out_sof) && n < 200);
            if (n >= 200) chk("bp_wait_timeout", 0, 1);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("bp_hold_data", int'(out_data), 8'h02);
               chk("bp_hold_valid", int'(out_valid), 1);
               chk("bp_in_ready_low", int'(in_ready), 0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_drain();
      chk("bp_csum", int'(last_csum), 8'hF6);
      chk("bp_frame_cnt", int'(frame_cnt), frames_sent % 256);

      // Three back-to-back frames with in_valid never dropping: no bubbles.
      sof_cyc = -1;
      for (int f = 0; f < 3; f++) send_frame(vecs[3].p, 0);
      wait_drain();
      chk("b2b_span_cycles", eof_cyc - sof_cyc, 3 * (FL + 2) - 1);
      chk("b2b_frame_cnt", int'(frame_cnt), frames_sent % 256);

      // Two-cycle gaps inside the payload.
      send_frame(vecs[4].p, 2);
      wait_drain();
      chk("gap_csum", int'(last_csum), int'(vecs[4].csum));

      // Reset mid-frame after two payload bytes, then a clean frame.
      send_byte(8'h99, 0);
      send_byte(8'h77, 0);
      do_reset();
      send_frame(vecs[5].p, 0);
      wait_drain();
      chk("post_rst_csum", int'(last_csum), int'(vecs[5].csum));
      chk("post_rst_frame_cnt", int'(frame_cnt), 1);

      // 256 frames of FF: checksum 04 and frame counter wraps back to zero.
      do_reset();
      saw_255 = 1'b0;
      for (int f = 0; f < 256; f++) send_frame(ff_frame, 0);
      wait_drain();
      chk("wrap_csum", int'(last_csum), int'(vecs[1].csum));
      chk("wrap_saw_255", int'(saw_255), 1);
      chk("wrap_frame_cnt", int'(frame_cnt), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
